// File: rtl/pim_dma_pkg.sv
// Shared types and constants for the PIM feeder/drain DMA.
package pim_dma_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MRD,
    S_MWAIT,
    S_PWR,
    S_POLL_A,
    S_POLL_C,
    S_PRD,
    S_PCAP,
    S_MWR,
    S_DONE
  } state_t;

  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_VALID_BIT = 1;
  localparam logic [31:0] ADDR_STRIDE    = 32'd4;

  // Result is ready once the PIM reports not-busy and valid together.
  function automatic logic stat_ready(input logic [31:0] stat);
    return !stat[STAT_BUSY_BIT] && stat[STAT_VALID_BIT];
  endfunction

endpackage

// File: rtl/pim_dma_memif.sv
// Single-outstanding memory master: request held until grant, read data
// accepted only from the cycle after a read grant.
module pim_dma_memif (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        launch_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  logic        req_q;
  logic        we_q;
  logic        rd_pend_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  assign gnt_o    = req_q & mem_gnt_i;
  assign rvalid_o = rd_pend_q & mem_rvalid_i;
  assign rdata_o  = mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      if (launch_i) begin
        req_q   <= 1'b1;
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= we_i ? wdata_i : '0;
      end else if (gnt_o) begin
        req_q <= 1'b0;
      end
      // A same-cycle rvalid alongside the grant is deliberately not honoured.
      if (gnt_o && !we_q) begin
        rd_pend_q <= 1'b1;
      end else if (rvalid_o) begin
        rd_pend_q <= 1'b0;
      end
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/pim_dma.sv
// PIM feeder/drain DMA: memory -> PIM write window, status poll, PIM result -> memory.
// Optional poll timeout enabled by defining PIM_DMA_POLL_TIMEOUT_EN.
module pim_dma
  import pim_dma_pkg::*;
#(
  parameter int unsigned LEN_W      = 12,
  parameter logic [31:0] IDLE_ADDR  = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [LEN_W-1:0] i_wr_len,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_rd_len,
  input  logic [31:0]      i_pim_wr_addr,
  input  logic [31:0]      i_pim_stat_addr,
  input  logic [31:0]      i_pim_rd_addr,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  input  logic             i_mem_gnt,
  input  logic             i_mem_rvalid,
  input  logic [31:0]      i_mem_rdata,
  output logic [31:0]      o_pim_address,
  output logic [31:0]      o_pim_data,
  input  logic [31:0]      i_pim_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int unsigned PCNT_W = $clog2(POLL_LIMIT + 1);

  state_t             state_q, state_d;
  logic [31:0]        src_q, dst_q;
  logic [31:0]        pim_wr_q, pim_stat_q, pim_rd_q;
  logic [LEN_W-1:0]   wr_len_q, rd_len_q;
  logic [LEN_W-1:0]   wcnt_q, rcnt_q, wcnt_inc, rcnt_inc;
  logic [PCNT_W-1:0]  poll_q, poll_inc;
  logic [31:0]        pim_addr_q, pim_addr_d, pim_data_q;
  logic               busy_q, done_q;
  logic               start_acc, stat_ok, timeout;
  logic               launch, launch_we;
  logic [31:0]        launch_addr, launch_wdata;
  logic               mem_gnt, mem_rvalid;
  logic [31:0]        mem_rdata;

  assign start_acc = (state_q == S_IDLE) && i_start;
  assign wcnt_inc  = wcnt_q + LEN_W'(1);
  assign rcnt_inc  = rcnt_q + LEN_W'(1);
  assign poll_inc  = poll_q + PCNT_W'(1);
  assign stat_ok   = stat_ready(i_pim_data);

`ifdef PIM_DMA_POLL_TIMEOUT_EN
  assign timeout = (state_q == S_POLL_C) && !stat_ok && (poll_inc == PCNT_W'(POLL_LIMIT));
`else
  assign timeout = 1'b0;
`endif

  pim_dma_memif u_memif (
    .clk_i        (i_clk),
    .rst_ni       (i_rst),
    .launch_i     (launch),
    .we_i         (launch_we),
    .addr_i       (launch_addr),
    .wdata_i      (launch_wdata),
    .mem_gnt_i    (i_mem_gnt),
    .mem_rvalid_i (i_mem_rvalid),
    .mem_rdata_i  (i_mem_rdata),
    .mem_req_o    (o_mem_req),
    .mem_we_o     (o_mem_we),
    .mem_addr_o   (o_mem_addr),
    .mem_wdata_o  (o_mem_wdata),
    .gnt_o        (mem_gnt),
    .rvalid_o     (mem_rvalid),
    .rdata_o      (mem_rdata)
  );

  // Next state plus memory launches; launches coincide with entry into MRD/MWR
  // so the registered request is visible in the same cycle as the state.
  always_comb begin
    state_d      = state_q;
    launch       = 1'b0;
    launch_we    = 1'b0;
    launch_addr  = src_q;
    launch_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_wr_len != '0) begin
            state_d     = S_MRD;
            launch      = 1'b1;
            launch_addr = i_src_addr;
          end else begin
            state_d = S_POLL_A;
          end
        end
      end
      S_MRD:   if (mem_gnt) state_d = S_MWAIT;
      S_MWAIT: if (mem_rvalid) state_d = S_PWR;
      S_PWR: begin
        if (wcnt_inc == wr_len_q) begin
          state_d = S_POLL_A;
        end else begin
          state_d     = S_MRD;
          launch      = 1'b1;
          launch_addr = src_q + ADDR_STRIDE;
        end
      end
      S_POLL_A: state_d = S_POLL_C;
      S_POLL_C: begin
        if (stat_ok) begin
          state_d = (rd_len_q != '0) ? S_PRD : S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
        end else begin
          state_d = S_POLL_A;
        end
      end
      S_PRD: state_d = S_PCAP;
      S_PCAP: begin
        state_d      = S_MWR;
        launch       = 1'b1;
        launch_we    = 1'b1;
        launch_addr  = dst_q;
        launch_wdata = i_pim_data;
      end
      S_MWR:   if (mem_gnt) state_d = (rcnt_inc == rd_len_q) ? S_DONE : S_PRD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pim_addr_d = IDLE_ADDR;
    case (state_d)
      S_PWR:    pim_addr_d = pim_wr_q;
      S_POLL_A: pim_addr_d = (state_q == S_IDLE) ? i_pim_stat_addr : pim_stat_q;
      S_PRD:    pim_addr_d = pim_rd_q;
      default:  pim_addr_d = IDLE_ADDR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      pim_wr_q   <= '0;
      pim_stat_q <= '0;
      pim_rd_q   <= '0;
      wr_len_q   <= '0;
      rd_len_q   <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      poll_q     <= '0;
      pim_addr_q <= IDLE_ADDR;
      pim_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pim_addr_q <= pim_addr_d;
      pim_data_q <= (state_d == S_PWR) ? mem_rdata : '0;
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      if (start_acc) begin
        src_q      <= i_src_addr;
        dst_q      <= i_dst_addr;
        pim_wr_q   <= i_pim_wr_addr;
        pim_stat_q <= i_pim_stat_addr;
        pim_rd_q   <= i_pim_rd_addr;
        wr_len_q   <= i_wr_len;
        rd_len_q   <= i_rd_len;
        wcnt_q     <= '0;
        rcnt_q     <= '0;
        poll_q     <= '0;
      end
      if (state_q == S_PWR) begin
        src_q  <= src_q + ADDR_STRIDE;
        wcnt_q <= wcnt_inc;
      end
      if ((state_q == S_MWR) && mem_gnt) begin
        dst_q  <= dst_q + ADDR_STRIDE;
        rcnt_q <= rcnt_inc;
      end
      if ((state_q == S_POLL_C) && !stat_ok) begin
        poll_q <= poll_inc;
      end
    end
  end

`ifdef PIM_DMA_POLL_TIMEOUT_EN
  logic err_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_pim_address = pim_addr_q;
  assign o_pim_data    = pim_data_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_pim_dma.sv
// Directed bench for pim_dma with a memory responder and a registered PIM model.
module tb_pim_dma;

  localparam int unsigned LEN_W     = 12;
  localparam logic [31:0] IDLE_A    = 32'hEEEE_0000;
  localparam logic [31:0] WR_A      = 32'h4000_0000;
  localparam logic [31:0] STAT_A    = 32'h4000_0010;
  localparam logic [31:0] RES_A     = 32'h4000_0020;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      src_addr, dst_addr, pim_wr_addr, pim_stat_addr, pim_rd_addr;
  logic [LEN_W-1:0] wr_len, rd_len;
  logic             mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [31:0]      pim_address, pim_data_o, pim_rsp;
  logic             busy, done, err;

  always #5 clk = ~clk;

  pim_dma #(
    .LEN_W      (LEN_W),
    .IDLE_ADDR  (IDLE_A),
    .POLL_LIMIT (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_start         (start),
    .i_src_addr      (src_addr),
    .i_wr_len        (wr_len),
    .i_dst_addr      (dst_addr),
    .i_rd_len        (rd_len),
    .i_pim_wr_addr   (pim_wr_addr),
    .i_pim_stat_addr (pim_stat_addr),
    .i_pim_rd_addr   (pim_rd_addr),
    .o_mem_req       (mem_req),
    .o_mem_we        (mem_we),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .i_mem_gnt       (mem_gnt),
    .i_mem_rvalid    (mem_rvalid),
    .i_mem_rdata     (mem_rdata),
    .o_pim_address   (pim_address),
    .o_pim_data      (pim_data_o),
    .i_pim_data      (pim_rsp),
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory responder: per-request grant delay, rvalid one cycle after a read grant.
  int          gnt_dly [0:3] = '{0, 2, 0, 1};
  int          req_idx = 0, wait_cnt = 0;
  bit          rv_due = 0, spur_rv = 0;
  logic [31:0] rv_data;
  logic [31:0] mr_addr [0:255];
  logic [31:0] mw_addr [0:255];
  logic [31:0] mw_data [0:255];
  int          mr_n = 0, mw_n = 0;

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  end

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hBAD0_BAD0;
    if (!rst_n) begin
      rv_due   = 0;
      wait_cnt = 0;
    end else begin
      if (rv_due) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rv_data;
        rv_due     = 0;
      end
      if (mem_req) begin
        if (wait_cnt >= gnt_dly[req_idx % 4]) begin
          mem_gnt  = 1'b1;
          wait_cnt = 0;
          req_idx++;
          if (mem_we) begin
            mw_addr[mw_n] = mem_addr;
            mw_data[mw_n] = mem_wdata;
            mw_n++;
          end else begin
            mr_addr[mr_n] = mem_addr;
            mr_n++;
            rv_due  = 1;
            rv_data = {16'hDA7A, mem_addr[15:0]};
            if (spur_rv) begin
              mem_rvalid = 1'b1;
              mem_rdata  = 32'hDEAD_BEEF;
            end
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // PIM model: response to the address of one cycle is visible the next cycle.
  logic [31:0] res_tab [0:3] = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004};
  logic [31:0] pw_log [0:255];
  int          pw_n = 0, stat_seen = 0, res_seen = 0;
  int          stat_base = 0, res_base = 0, busy_polls = 0;

  initial pim_rsp = 32'hFFFF_FFF1;

  always @(posedge clk) begin
    if (pim_address == STAT_A) begin
      pim_rsp   <= ((stat_seen - stat_base) < busy_polls) ? 32'h1 : 32'h2;
      stat_seen <= stat_seen + 1;
    end else if (pim_address == RES_A) begin
      pim_rsp  <= res_tab[(res_seen - res_base) % 4];
      res_seen <= res_seen + 1;
    end else begin
      pim_rsp <= 32'hFFFF_FFF1;
    end
    if (pim_address == WR_A) begin
      pw_log[pw_n] <= pim_data_o;
      pw_n         <= pw_n + 1;
    end
  end

  int pw_b, mr_b, mw_b, lat, blow;

  task automatic start_xfer(input logic [31:0] src, input logic [LEN_W-1:0] wl,
                            input logic [31:0] dst, input logic [LEN_W-1:0] rl, input int polls);
    @(negedge clk);
    busy_polls = polls;
    stat_base  = stat_seen;
    res_base   = res_seen;
    pw_b = pw_n; mr_b = mr_n; mw_b = mw_n;
    src_addr = src; wr_len = wl; dst_addr = dst; rd_len = rl;
    pim_wr_addr = WR_A; pim_stat_addr = STAT_A; pim_rd_addr = RES_A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int l, output int bl);
    l  = 1;
    bl = 0;
    while (!done && l < budget) begin
      if (!busy) bl++;
      @(negedge clk);
      l++;
    end
    if (!done) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    src_addr = '0; dst_addr = '0; wr_len = '0; rd_len = '0;
    pim_wr_addr = WR_A; pim_stat_addr = STAT_A; pim_rd_addr = RES_A;
    repeat (3) @(negedge clk);
    check_eq("rst_req",   {31'd0, mem_req}, 32'd0);
    check_eq("rst_paddr", pim_address, IDLE_A);
    check_eq("rst_flags", {29'd0, busy, done, err}, 32'd0);
    rst_n = 1'b1;

    // Basic write phase, polling, drain.
    start_xfer(32'h100, 12'd3, 32'h200, 12'd2, 5);
    wait_done(400, lat, blow);
    check_eq("t1_busy_low",  blow, 32'd0);
    check_eq("t1_pw_count",  pw_n - pw_b, 32'd3);
    check_eq("t1_pw0",       pw_log[pw_b],     32'hDA7A_0100);
    check_eq("t1_pw1",       pw_log[pw_b + 1], 32'hDA7A_0104);
    check_eq("t1_pw2",       pw_log[pw_b + 2], 32'hDA7A_0108);
    check_eq("t1_mrd2_addr", mr_addr[mr_b + 2], 32'h108);
    check_eq("t2_polls",     stat_seen - stat_base, 32'd6);
    check_eq("t2_mw_count",  mw_n - mw_b, 32'd2);
    check_eq("t2_mw0_addr",  mw_addr[mw_b], 32'h200);
    check_eq("t2_mw0_data",  mw_data[mw_b], 32'hC0DE_0001);
    check_eq("t2_mw1_addr",  mw_addr[mw_b + 1], 32'h204);
    check_eq("t2_mw1_data",  mw_data[mw_b + 1], 32'hC0DE_0002);
    check_eq("t2_done_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("t2_done_pulse", {31'd0, done}, 32'd0);
    check_eq("t2_idle_paddr", pim_address, IDLE_A);

    // Zero lengths: single poll, done three cycles after start.
    start_xfer(32'h700, 12'd0, 32'h800, 12'd0, 0);
    wait_done(50, lat, blow);
    check_eq("t3_latency", lat, 32'd3);
    check_eq("t3_no_mem",  (mr_n - mr_b) + (mw_n - mw_b), 32'd0);
    check_eq("t3_polls",   stat_seen - stat_base, 32'd1);

    // Start while busy is ignored; same-cycle rvalid with grant is ignored.
    spur_rv = 1;
    start_xfer(32'h300, 12'd2, 32'h600, 12'd1, 0);
    for (int i = 0; i < 100 && (pw_n - pw_b) < 1; i++) @(negedge clk);
    src_addr = 32'h900; dst_addr = 32'hA00; wr_len = 12'd5; rd_len = 12'd3;
    pim_wr_addr = 32'h5000_0000; pim_stat_addr = 32'h5000_0010; pim_rd_addr = 32'h5000_0020;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400, lat, blow);
    spur_rv = 0;
    check_eq("t4_pw_count", pw_n - pw_b, 32'd2);
    check_eq("t4_pw1",      pw_log[pw_b + 1], 32'hDA7A_0304);
    check_eq("t4_mrd1",     mr_addr[mr_b + 1], 32'h304);
    check_eq("t4_mw_addr",  mw_addr[mw_b], 32'h600);
    check_eq("t4_mw_count", mw_n - mw_b, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t4_no_restart", {31'd0, busy}, 32'd0);

    // Reset during the second PIM write.
    start_xfer(32'h100, 12'd3, 32'h200, 12'd1, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 100 && seen < 2; i++) begin
        if (pim_address == WR_A) seen++;
        if (seen < 2) @(negedge clk);
      end
      check_eq("t5_reached_pwr2", seen, 32'd2);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_paddr", pim_address, IDLE_A);
    check_eq("t5_rst_pdata", pim_data_o, 32'd0);
    check_eq("t5_rst_mem",   {30'd0, mem_req, mem_we}, 32'd0);
    check_eq("t5_rst_maddr", mem_addr, 32'd0);
    check_eq("t5_rst_flags", {29'd0, busy, done, err}, 32'd0);
    rst_n = 1'b1;
    start_xfer(32'h500, 12'd1, 32'h540, 12'd1, 1);
    wait_done(300, lat, blow);
    check_eq("t5_pw_count", pw_n - pw_b, 32'd1);
    check_eq("t5_pw0",      pw_log[pw_b], 32'hDA7A_0500);
    check_eq("t5_mw_addr",  mw_addr[mw_b], 32'h540);
    check_eq("t5_mw_data",  mw_data[mw_b], 32'hC0DE_0001);

`ifdef PIM_DMA_POLL_TIMEOUT_EN
    // Stuck busy status: timeout after four polls, drain skipped.
    start_xfer(32'h0, 12'd0, 32'h200, 12'd1, 1000);
    wait_done(200, lat, blow);
    check_eq("t6_polls", stat_seen - stat_base, 32'd4);
    check_eq("t6_err",   {31'd0, err}, 32'd1);
    check_eq("t6_no_mw", mw_n - mw_b, 32'd0);
    @(negedge clk);
    check_eq("t6_err_sticky", {31'd0, err}, 32'd1);
    start_xfer(32'h0, 12'd0, 32'h200, 12'd0, 0);
    check_eq("t6_err_clear", {31'd0, err}, 32'd0);
    wait_done(50, lat, blow);
`else
    check_eq("t6_err_tied", {31'd0, err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
